// File: rtl/s3g_rx_buf.sv
// S3G packet receiver: frames 0xD5/len/payload/CRC8 from UART bytes into a payload buffer.
// Status 1 cycle after the deciding byte, rd_data 1 cycle after rd_addr; no backpressure, bytes arriving while a packet is held are dropped.
module s3g_rx_buf #(
   parameter int MAX_PAYLOAD    = 32,
   parameter int ADDR_W         = 5,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TO_W           = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [7:0]        payload_len,
   output logic              packet_ready,
   input  logic              packet_ack,
   output logic              err_crc,
   output logic              err_len,
   output logic              err_timeout,
   output logic              err_overrun,
   output logic [7:0]        crc_err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CRC,
      S_READY
   } state_t;

   localparam logic [7:0]      SOF     = 8'hD5;
   localparam logic [7:0]      MAX_LEN = 8'(MAX_PAYLOAD);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state_q, state_d;
   logic [7:0]      len_d;
   logic [7:0]      crc_q, crc_d;
   logic [7:0]      idx_q, idx_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]      crc_cnt_d;
   logic            err_crc_d, err_len_d, err_timeout_d, err_overrun_d;
   logic            mem_we;
   logic [7:0]      mem_q [0:(1<<ADDR_W)-1];

   // Maxim/iButton CRC8, one data bit per iteration, LSB first.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] din);
      logic [7:0] c;
      logic [7:0] d;
      c = crc_in;
      d = din;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[0])
            c = (c >> 1) ^ 8'h8C;
         else
            c = c >> 1;
         d = d >> 1;
      end
      return c;
   endfunction

   always_comb begin
      state_d       = state_q;
      len_d         = payload_len;
      crc_d         = crc_q;
      idx_d         = idx_q;
      to_cnt_d      = '0;
      crc_cnt_d     = crc_err_cnt;
      err_crc_d     = 1'b0;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;
      mem_we        = 1'b0;

      // A byte landing in the expiry cycle takes priority over the timeout.
      if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CRC) begin
         if (rx_done) begin
            to_cnt_d = '0;
         end else if (to_cnt_q == TO_LAST) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (rx_done && rx_data == SOF)
               state_d = S_LEN;
         end
         S_LEN: begin
            if (rx_done) begin
               if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
                  err_len_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  len_d   = rx_data;
                  crc_d   = 8'd0;
                  idx_d   = 8'd0;
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_done) begin
               mem_we = 1'b1;
               crc_d  = crc8_step(crc_q, rx_data);
               idx_d  = idx_q + 8'd1;
               if (idx_q == payload_len - 8'd1)
                  state_d = S_CRC;
            end
         end
         S_CRC: begin
            if (rx_done) begin
               if (rx_data == crc_q) begin
                  state_d = S_READY;
               end else begin
                  err_crc_d = 1'b1;
                  state_d   = S_IDLE;
                  if (crc_err_cnt != 8'hFF)
                     crc_cnt_d = crc_err_cnt + 8'd1;
               end
            end
         end
         S_READY: begin
            // An ack in the same cycle as a byte frees the buffer first, so the byte sees IDLE rules.
            if (packet_ack)
               state_d = (rx_done && rx_data == SOF) ? S_LEN : S_IDLE;
            else if (rx_done)
               err_overrun_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         payload_len  <= 8'd0;
         crc_q        <= 8'd0;
         idx_q        <= 8'd0;
         to_cnt_q     <= '0;
         crc_err_cnt  <= 8'd0;
         packet_ready <= 1'b0;
         err_crc      <= 1'b0;
         err_len      <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         state_q      <= state_d;
         payload_len  <= len_d;
         crc_q        <= crc_d;
         idx_q        <= idx_d;
         to_cnt_q     <= to_cnt_d;
         crc_err_cnt  <= crc_cnt_d;
         packet_ready <= (state_d == S_READY);
         err_crc      <= err_crc_d;
         err_len      <= err_len_d;
         err_timeout  <= err_timeout_d;
         err_overrun  <= err_overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[idx_q[ADDR_W-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rd_data <= 8'd0;
      else
         rd_data <= mem_q[rd_addr];
   end

endmodule
